// File: rtl/gearbox_66_64_tx.sv
// Transmit 64b/66b gearbox: {head, 2 x 32-bit payload} blocks in, one 32-bit line word out every cycle.
// Optional payload scrambler (1+x^39+x^58) enabled by defining GEARBOX_TX_SCRAMBLE_EN.
//
// state  | meaning
// W_EVEN | next accepted word is a block start: header + payload bits [31:0]
// W_ODD  | next accepted word is payload bits [63:32]
module gearbox_66_64_tx #(
   parameter logic [1:0]  UNDERRUN_HEAD = 2'b00,
   parameter logic [31:0] UNDERRUN_DATA = 32'h0000_0000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:0] data_i,
   input  logic [1:0]  head_i,
   input  logic        valid_i,
   output logic        ready_o,
   output logic [31:0] data_o,
   output logic        data_valid_o,
   output logic        underrun_o,
   output logic [5:0]  seq_o
);

   typedef enum logic {W_EVEN, W_ODD} word_t;

   word_t       wstate, wstate_nxt;
   logic [5:0]  seq, seq_nxt;
   logic        ready_q;
   logic [31:0] buf_q, buf_nxt;
   logic [6:0]  occ_q, occ_nxt, comb_occ;
   logic [63:0] comb_bits;
   logic [33:0] word_ins;
   logic [6:0]  ins_w;
   logic [1:0]  head_sel;
   logic [31:0] data_sel, data_enc;
   logic        out_fire;

   assign head_sel = valid_i ? head_i : UNDERRUN_HEAD;
   assign data_sel = valid_i ? data_i : UNDERRUN_DATA;

`ifdef GEARBOX_TX_SCRAMBLE_EN
   logic [57:0] scr_q, scr_nxt;

   // Self-synchronous: each scrambled bit is fed back into the state, LSB first.
   always_comb begin
      scr_nxt  = scr_q;
      data_enc = '0;
      for (int i = 0; i < 32; i++) begin
         data_enc[i] = data_sel[i] ^ scr_nxt[38] ^ scr_nxt[57];
         scr_nxt     = {scr_nxt[56:0], data_sel[i] ^ scr_nxt[38] ^ scr_nxt[57]};
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         scr_q <= '1;
      end else if (ready_q) begin
         scr_q <= scr_nxt;
      end
   end
`else
   assign data_enc = data_sel;
`endif

   always_comb begin
      seq_nxt    = (seq == 6'd32) ? 6'd0 : seq + 6'd1;
      wstate_nxt = wstate;
      word_ins   = '0;
      ins_w      = '0;
      out_fire   = 1'b0;
      if (ready_q) begin
         case (wstate)
            W_EVEN: begin
               word_ins   = {data_enc, head_sel};
               ins_w      = 7'd34;
               wstate_nxt = W_ODD;
            end
            W_ODD: begin
               word_ins   = {2'b00, data_enc};
               ins_w      = 7'd32;
               wstate_nxt = W_EVEN;
            end
            default: wstate_nxt = W_EVEN;
         endcase
      end
      // occ_q + ins_w never exceeds 64, so the shifted word always fits.
      comb_bits = {32'h0, buf_q} | ({30'h0, word_ins} << occ_q);
      comb_occ  = occ_q + ins_w;
      if (comb_occ >= 7'd32) begin
         out_fire = 1'b1;
         occ_nxt  = comb_occ - 7'd32;
         buf_nxt  = comb_bits[63:32];
      end else begin
         occ_nxt  = comb_occ;
         buf_nxt  = comb_bits[31:0];
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         wstate       <= W_EVEN;
         seq          <= '0;
         ready_q      <= 1'b1;
         buf_q        <= '0;
         occ_q        <= '0;
         data_o       <= '0;
         data_valid_o <= 1'b0;
         underrun_o   <= 1'b0;
      end else begin
         wstate  <= wstate_nxt;
         seq     <= seq_nxt;
         ready_q <= (seq_nxt != 6'd32);
         buf_q   <= buf_nxt;
         occ_q   <= occ_nxt;
         if (out_fire) begin
            data_o       <= comb_bits[31:0];
            data_valid_o <= 1'b1;
         end
         if (ready_q && !valid_i) begin
            underrun_o <= 1'b1;
         end
      end
   end

   assign ready_o = ready_q;
   assign seq_o   = seq;

endmodule

// File: tb/tb_gearbox_66_64_tx.sv
// Bench for gearbox_66_64_tx: bit-level line model feeding a word scoreboard, plus a receive-side
// loopback that rebuilds 66-bit blocks from data_o. Honors GEARBOX_TX_SCRAMBLE_EN.
module tb_gearbox_66_64_tx;

   localparam logic [1:0]  UH = 2'b00;
   localparam logic [31:0] UD = 32'h0000_0000;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic [31:0] data_i;
   logic [1:0]  head_i;
   logic        valid_i;
   logic        ready_o;
   logic [31:0] data_o;
   logic        data_valid_o;
   logic        underrun_o;
   logic [5:0]  seq_o;

   gearbox_66_64_tx dut (
      .clk_i(clk_i), .rst_i(rst_i), .data_i(data_i), .head_i(head_i), .valid_i(valid_i),
      .ready_o(ready_o), .data_o(data_o), .data_valid_o(data_valid_o),
      .underrun_o(underrun_o), .seq_o(seq_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [1:0]  h;
      logic [31:0] d0, d1, e0, e1;
   } vec_t;

   vec_t        vt[4];
   int          n_pass = 0;
   int          n_total = 0;
   logic [5:0]  mseq;
   logic        modd, m_under;
   logic [1:0]  s_head;
   logic [31:0] s_d0;
   logic [57:0] m_scr, rx_scr;
   bit          bitq[$];
   bit          rxbits[$];
   logic [31:0] expq[$];
   logic [65:0] sentq[$];

   task automatic check(input string nm, input logic [65:0] act, input logic [65:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   task automatic model_clear();
      mseq = '0; modd = 1'b0; m_under = 1'b0;
      m_scr = '1; rx_scr = '1;
      bitq.delete(); rxbits.delete(); expq.delete(); sentq.delete();
   endtask

   task automatic do_reset();
      rst_i = 1'b0; valid_i = 1'b0; data_i = '0; head_i = '0;
      @(posedge clk_i); #1;
      check("rst_data_o", data_o, 0);
      check("rst_data_valid", data_valid_o, 0);
      check("rst_underrun", underrun_o, 0);
      check("rst_seq", seq_o, 0);
      check("rst_ready", ready_o, 1);
      model_clear();
      rst_i = 1'b1;
   endtask

   task automatic rx_block();
      logic [1:0]  h;
      logic [63:0] p;
      logic [65:0] exp;
      h[0] = rxbits.pop_front();
      h[1] = rxbits.pop_front();
      for (int i = 0; i < 64; i++) begin
         p[i] = rxbits.pop_front();
`ifdef GEARBOX_TX_SCRAMBLE_EN
         begin
            logic b;
            b = p[i];
            p[i] = b ^ rx_scr[38] ^ rx_scr[57];
            rx_scr = {rx_scr[56:0], b};
         end
`endif
      end
      exp = (sentq.size() > 0) ? sentq.pop_front() : 66'h3_FFFF_FFFF_FFFF_FFFF;
      check("loopback_block", {h, p}, exp);
   endtask

   task automatic step(input logic v, input logic [1:0] h, input logic [31:0] d);
      logic [31:0] w, sw, ew;
      logic [1:0]  hh;
      check("ready", ready_o, (mseq != 6'd32));
      check("seq", seq_o, mseq);
      valid_i = v; head_i = h; data_i = d;
      if (mseq != 6'd32) begin
         hh = v ? h : UH;
         w  = v ? d : UD;
         if (!v) m_under = 1'b1;
         sw = w;
`ifdef GEARBOX_TX_SCRAMBLE_EN
         for (int i = 0; i < 32; i++) begin
            sw[i] = w[i] ^ m_scr[38] ^ m_scr[57];
            m_scr = {m_scr[56:0], sw[i]};
         end
`endif
         if (!modd) begin
            s_head = hh; s_d0 = w;
            bitq.push_back(hh[0]);
            bitq.push_back(hh[1]);
         end else begin
            sentq.push_back({s_head, w, s_d0});
         end
         for (int i = 0; i < 32; i++) bitq.push_back(sw[i]);
         modd = ~modd;
      end
      mseq = (mseq == 6'd32) ? 6'd0 : mseq + 6'd1;
      if (bitq.size() >= 32) begin
         for (int i = 0; i < 32; i++) ew[i] = bitq.pop_front();
         expq.push_back(ew);
      end
      @(posedge clk_i); #1;
      ew = (expq.size() > 0) ? expq.pop_front() : ~data_o;
      check("data_o", data_o, ew);
      check("data_valid", data_valid_o, 1);
      check("underrun", underrun_o, m_under);
      for (int i = 0; i < 32; i++) rxbits.push_back(data_o[i]);
      if (rxbits.size() >= 66) rx_block();
   endtask

   initial begin
      vt[0] = '{h: 2'b01, d0: 32'hFFFF_FFFF, d1: 32'h0000_0000, e0: 32'hFFFF_FFFD, e1: 32'h0000_0003};
      vt[1] = '{h: 2'b10, d0: 32'h0000_0000, d1: 32'hFFFF_FFFF, e0: 32'h0000_0002, e1: 32'hFFFF_FFFC};
      vt[2] = '{h: 2'b11, d0: 32'h1234_5678, d1: 32'h9ABC_DEF0, e0: 32'h48D1_59E3, e1: 32'h6AF3_7BC0};
      vt[3] = '{h: 2'b00, d0: 32'h0000_0000, d1: 32'h8000_0001, e0: 32'h0000_0000, e1: 32'h0000_0004};
      rst_i = 1'b0; valid_i = 1'b0; data_i = '0; head_i = '0;
      model_clear();
      repeat (2) @(posedge clk_i);
      #1;

      for (int k = 0; k < 4; k++) begin
         do_reset();
         step(1'b1, vt[k].h, vt[k].d0);
`ifndef GEARBOX_TX_SCRAMBLE_EN
         check("vec_word0", data_o, vt[k].e0);
`endif
         step(1'b1, vt[k].h, vt[k].d1);
`ifndef GEARBOX_TX_SCRAMBLE_EN
         check("vec_word1", data_o, vt[k].e1);
`endif
      end

      // Continuous stream: over two and a half 33-cycle frames, ready drops only at seq 32.
      do_reset();
      for (int c = 0; c < 85; c++) step(1'b1, 2'($urandom), $urandom);

      // All-zero payload, head 01: exercises scrambler reference when enabled.
      do_reset();
      for (int c = 0; c < 40; c++) step(1'b1, 2'b01, 32'h0);

      // Single missed ready cycle on an even word index.
      do_reset();
      for (int c = 0; c < 50; c++) step(c != 10, 2'($urandom), $urandom);
      check("underrun_sticky", underrun_o, 1);

      // Reset mid-block at seq 17, then the first block must look like a fresh start.
      do_reset();
      while (mseq != 6'd17) step(1'b1, 2'($urandom), $urandom);
      do_reset();
      step(1'b1, 2'b01, 32'hFFFF_FFFF);
`ifndef GEARBOX_TX_SCRAMBLE_EN
      check("post_rst_word0", data_o, 32'hFFFF_FFFD);
`endif
      step(1'b1, 2'b01, 32'h0000_0000);
`ifndef GEARBOX_TX_SCRAMBLE_EN
      check("post_rst_word1", data_o, 32'h0000_0003);
`endif
      for (int c = 0; c < 6; c++) step(1'b1, 2'($urandom), $urandom);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
